// File: rtl/usb3_skp_sched.sv
// TX lane scheduler: merges link-layer words with credited SKP words. Latency 1 cycle; in_ready drops while a SKP word is inserted.
// Optional macro USB3_SKP_INHIBIT_EN adds skp_inhibit, which holds off insertion while credits keep accruing.
module usb3_skp_sched #(
    parameter int unsigned INTERVAL_CYC = 177,
    parameter int unsigned MAX_PEND     = 4,
    parameter logic [31:0] IDLE_DATA    = 32'h0000_0000
) (
    input  logic        local_clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic [31:0] in_data,
    input  logic [3:0]  in_datak,
    input  logic        in_valid,
    input  logic        in_start,
    input  logic        in_end,
`ifdef USB3_SKP_INHIBIT_EN
    input  logic        skp_inhibit,
`endif
    output logic        in_ready,
    output logic [31:0] out_data,
    output logic [3:0]  out_datak,
    output logic        out_skp,
    output logic [2:0]  pend_cnt,
    output logic        err_skp_overflow
);

    localparam logic [7:0]  SYM_LAST = 8'(INTERVAL_CYC - 1);
    localparam logic [2:0]  PEND_MAX = 3'(MAX_PEND);
    localparam logic [31:0] SKP_WORD = 32'h3C3C_3C3C;

    logic [7:0]  sym_q, sym_d;
    logic [2:0]  pend_q, pend_d;
    logic        err_q, err_d;
    logic        open_q, open_d;
    logic [31:0] data_q, data_d;
    logic [3:0]  datak_q, datak_d;
    logic        skp_q, skp_d;

    logic inhibit;
    logic ins;
    logic accept;
    logic credit;

`ifdef USB3_SKP_INHIBIT_EN
    assign inhibit = skp_inhibit;
`else
    assign inhibit = 1'b0;
`endif

    // SKP only goes out between packets, so a start word offered alongside a pending credit waits.
    assign ins      = enable & (pend_q != 3'd0) & ~open_q & ~inhibit;
    assign in_ready = ~ins;
    assign accept   = in_valid & ~ins;
    assign credit   = enable & (sym_q == SYM_LAST);

    always_comb begin
        sym_d   = sym_q;
        pend_d  = pend_q;
        err_d   = err_q;
        open_d  = open_q;
        data_d  = IDLE_DATA;
        datak_d = 4'h0;
        skp_d   = 1'b0;

        if (!enable) begin
            sym_d  = 8'd0;
            pend_d = 3'd0;
        end else begin
            sym_d = credit ? 8'd0 : sym_q + 8'd1;
            if (credit && !ins) begin
                if (pend_q == PEND_MAX) err_d  = 1'b1;
                else                    pend_d = pend_q + 3'd1;
            end else if (!credit && ins) begin
                pend_d = pend_q - 3'd1;
            end
        end

        if (accept) begin
            if (in_end)        open_d = 1'b0;
            else if (in_start) open_d = 1'b1;
        end

        if (ins) begin
            data_d  = SKP_WORD;
            datak_d = 4'hF;
            skp_d   = 1'b1;
        end else if (accept) begin
            data_d  = in_data;
            datak_d = in_datak;
        end
    end

    always_ff @(posedge local_clk) begin
        if (!reset_n) begin
            sym_q   <= 8'd0;
            pend_q  <= 3'd0;
            err_q   <= 1'b0;
            open_q  <= 1'b0;
            data_q  <= IDLE_DATA;
            datak_q <= 4'h0;
            skp_q   <= 1'b0;
        end else begin
            sym_q   <= sym_d;
            pend_q  <= pend_d;
            err_q   <= err_d;
            open_q  <= open_d;
            data_q  <= data_d;
            datak_q <= datak_d;
            skp_q   <= skp_d;
        end
    end

    assign out_data         = data_q;
    assign out_datak        = datak_q;
    assign out_skp          = skp_q;
    assign pend_cnt         = pend_q;
    assign err_skp_overflow = err_q;

endmodule

// File: tb/tb_usb3_skp_sched.sv
// Randomized bench for usb3_skp_sched against a credit-counting reference model.
// Define USB3_SKP_INHIBIT_EN for both files to exercise skp_inhibit.
module tb_usb3_skp_sched;

    localparam int          IV   = 177;
    localparam int          MP   = 4;
    localparam logic [31:0] IDLE = 32'h0000_0000;

    logic        local_clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic [31:0] in_data;
    logic [3:0]  in_datak;
    logic        in_valid;
    logic        in_start;
    logic        in_end;
    logic        skp_inhibit;
    logic        in_ready;
    logic [31:0] out_data;
    logic [3:0]  out_datak;
    logic        out_skp;
    logic [2:0]  pend_cnt;
    logic        err_skp_overflow;

    always #5 local_clk = ~local_clk;

    usb3_skp_sched #(.INTERVAL_CYC(IV), .MAX_PEND(MP), .IDLE_DATA(IDLE)) dut (
        .local_clk        (local_clk),
        .reset_n          (reset_n),
        .enable           (enable),
        .in_data          (in_data),
        .in_datak         (in_datak),
        .in_valid         (in_valid),
        .in_start         (in_start),
        .in_end           (in_end),
`ifdef USB3_SKP_INHIBIT_EN
        .skp_inhibit      (skp_inhibit),
`endif
        .in_ready         (in_ready),
        .out_data         (out_data),
        .out_datak        (out_datak),
        .out_skp          (out_skp),
        .pend_cnt         (pend_cnt),
        .err_skp_overflow (err_skp_overflow)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else begin
            n_fail++;
            if (n_fail <= 40) $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: credits are counted from enabled cycles elapsed, not from a wrapping counter.
    int          m_n;
    int          m_pend;
    bit          m_err;
    bit          m_open;
    logic [31:0] e_data;
    logic [3:0]  e_k;
    bit          e_skp;

    task automatic model_reset();
        m_n = 0; m_pend = 0; m_err = 0; m_open = 0;
        e_data = IDLE; e_k = 4'h0; e_skp = 0;
    endtask

    task automatic cycle(output bit acc);
        bit ins;
        bit credit;
        int tot;
        #1;
        ins = enable && (m_pend > 0) && !m_open && !skp_inhibit;
        chk("in_ready", in_ready, !ins);
        acc = reset_n && in_valid && !ins;
        if (!reset_n) begin
            model_reset();
        end else begin
            credit = enable && ((m_n % IV) == IV - 1);
            m_n    = enable ? m_n + 1 : 0;
            if (ins) begin
                e_data = 32'h3C3C3C3C; e_k = 4'hF; e_skp = 1;
            end else if (acc) begin
                e_data = in_data; e_k = in_datak; e_skp = 0;
                if (in_end) m_open = 0;
                else if (in_start) m_open = 1;
            end else begin
                e_data = IDLE; e_k = 4'h0; e_skp = 0;
            end
            if (!enable) m_pend = 0;
            else begin
                tot = m_pend + int'(credit) - int'(ins);
                if (tot > MP) begin
                    tot   = MP;
                    m_err = 1;
                end
                m_pend = tot;
            end
        end
        @(posedge local_clk);
        #1;
        chk("out_data", out_data, e_data);
        chk("out_datak", out_datak, e_k);
        chk("out_skp", out_skp, e_skp);
        chk("pend_cnt", pend_cnt, m_pend);
        chk("err_ovf", err_skp_overflow, m_err);
    endtask

    task automatic idle(input int n);
        bit a;
        in_valid = 0;
        repeat (n) cycle(a);
    endtask

    task automatic do_reset();
        bit a;
        reset_n = 0; in_valid = 0;
        cycle(a);
        reset_n = 1;
    endtask

    task automatic send_pkt(input int len, input int bubble_pct);
        bit a;
        for (int i = 0; i < len; i++) begin
            while ($urandom_range(99) < bubble_pct) begin
                in_valid = 0; in_start = 1'($urandom); in_end = 1'($urandom);
                in_data = $urandom;
                cycle(a);
            end
            in_valid = 1; in_data = $urandom; in_datak = 4'($urandom);
            in_start = (i == 0); in_end = (i == len - 1);
            a = 0;
            for (int t = 0; t < 20 && !a; t++) cycle(a);
            if (!a) chk("accept_timeout", 0, 1);
        end
        in_valid = 0; in_start = 0; in_end = 0;
    endtask

    // Cycles from the first enabled cycle until a SKP word appears on the output (spec cycle numbering).
    task automatic first_skp(input string tag, input int exp);
        bit a;
        int k;
        k = -1;
        in_valid = 0;
        for (int c = 0; c < 400 && k < 0; c++) begin
            cycle(a);
            if (out_skp === 1'b1) k = c + 1;
        end
        chk(tag, k, exp);
    endtask

    task automatic count_skp(input string tag, input int n, input int exp);
        bit a;
        int s;
        s = 0;
        in_valid = 0;
        for (int c = 0; c < n; c++) begin
            cycle(a);
            if (out_skp === 1'b1) s++;
        end
        chk(tag, s, exp);
    endtask

    initial begin
        reset_n = 0; enable = 0; in_valid = 0; in_start = 0; in_end = 0;
        in_data = 0; in_datak = 0; skp_inhibit = 0;
        repeat (2) @(posedge local_clk);
        #1;
        model_reset();
        chk("rst_out_data", out_data, IDLE);
        chk("rst_out_datak", out_datak, 0);
        chk("rst_out_skp", out_skp, 0);
        chk("rst_pend", pend_cnt, 0);
        chk("rst_err", err_skp_overflow, 0);
        reset_n = 1;

        // Idle lane: first SKP at cycle 178, then every 177 cycles.
        enable = 1;
        first_skp("first_skp", 178);
        first_skp("second_skp", 177);

        // 400-word packet: two credits held, drained right after the end word.
        do_reset();
        idle(10);
        send_pkt(400, 0);
        chk("pkt400_pend", pend_cnt, 2);
        send_pkt(5, 0);
        idle(5);

        // 1000-word packet: saturation at MAX_PEND and exactly four SKP words after.
        do_reset();
        send_pkt(1000, 0);
        chk("sat_pend", pend_cnt, MP);
        chk("sat_err", err_skp_overflow, 1);
        count_skp("sat_burst", 8, MP);

        // Reset on the first drain cycle with three credits pending.
        do_reset();
        send_pkt(600, 0);
        chk("pre_rst_pend", pend_cnt, 3);
        do_reset();
        chk("post_rst_skp", out_skp, 0);
        chk("post_rst_pend", pend_cnt, 0);
        first_skp("post_rst_first", 178);

`ifdef USB3_SKP_INHIBIT_EN
        do_reset();
        skp_inhibit = 1;
        count_skp("inh_none", 800, 0);
        chk("inh_pend", pend_cnt, MP);
        skp_inhibit = 0;
        count_skp("inh_release", 6, MP);
`endif

        // Random traffic, enable gaps and occasional resets.
        for (int it = 0; it < 60; it++) begin
            case ($urandom_range(9))
                0: begin
                    enable = 0;
                    send_pkt($urandom_range(1, 40), 20);
                    idle($urandom_range(0, 20));
                    enable = 1;
                end
                1: send_pkt($urandom_range(300, 700), 10);
                2: if ($urandom_range(3) == 0) do_reset();
                3: begin
`ifdef USB3_SKP_INHIBIT_EN
                    skp_inhibit = 1;
                    send_pkt($urandom_range(1, 200), 20);
                    idle($urandom_range(0, 100));
                    skp_inhibit = 0;
`else
                    idle($urandom_range(0, 200));
`endif
                end
                default: begin
                    send_pkt($urandom_range(1, 200), 20);
                    idle($urandom_range(0, 8));
                end
            endcase
        end
        idle(10);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
